// File: rtl/tick_bcd_counter_disp_pkg.sv
// tick_bcd_counter_disp_pkg: seven-segment patterns and BCD helpers shared by the counter/display block.
// Rev 1.0
`default_nettype none
package tick_bcd_counter_disp_pkg;

  localparam int BCD_W = 4;

  // Active-low {a,b,c,d,e,f,g,dp}; dp (bit 0) is always off
  localparam logic [7:0] SEG_0     = 8'b0000_0011;
  localparam logic [7:0] SEG_1     = 8'b1001_1111;
  localparam logic [7:0] SEG_2     = 8'b0010_0101;
  localparam logic [7:0] SEG_3     = 8'b0000_1101;
  localparam logic [7:0] SEG_4     = 8'b1001_1001;
  localparam logic [7:0] SEG_5     = 8'b0100_1001;
  localparam logic [7:0] SEG_6     = 8'b0100_0001;
  localparam logic [7:0] SEG_7     = 8'b0001_1111;
  localparam logic [7:0] SEG_8     = 8'b0000_0001;
  localparam logic [7:0] SEG_9     = 8'b0001_1001;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  function automatic logic [15:0] int_to_bcd(input int unsigned value);
    logic [15:0] r;
    int unsigned v;
    r = '0;
    v = value;
    for (int i = 0; i < 4; i++) begin
      r[i*BCD_W +: BCD_W] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tick_bcd_counter_disp_if.sv
// tick_bcd_counter_disp_if: control inputs and display/status outputs of the counter block.
// Rev 1.0
`default_nettype none
interface tick_bcd_counter_disp_if #(
  parameter int NUM_DIGITS = 2
);
  logic                    en;
  logic                    dir;
  logic                    clear;
  logic [4*NUM_DIGITS-1:0] count;
  logic                    tick;
  logic                    led;
  logic [7:0]              seg;
  logic [NUM_DIGITS-1:0]   an;

  modport master (output en, dir, clear, input count, tick, led, seg, an);
  modport slave  (input en, dir, clear, output count, tick, led, seg, an);
endinterface
`default_nettype wire

// File: rtl/tick_bcd_counter_disp_seg7_decode.sv
// seg7_decode: combinational BCD digit to active-low seven-segment pattern; non-BCD codes blank.
// Rev 1.0
`default_nettype none
module seg7_decode
  import tick_bcd_counter_disp_pkg::*;
(
  input  logic [BCD_W-1:0] bcd_i,
  output logic [7:0]       seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/tick_bcd_counter_disp.sv
// tick_bcd_counter_disp: prescaled up/down BCD counter modulo MODULUS, wrap LED, multiplexed 7-seg display.
// Rev 1.0
`default_nettype none
module tick_bcd_counter_disp
  import tick_bcd_counter_disp_pkg::*;
#(
  parameter int TICK_DIV       = 8388608,
  parameter int SCAN_DIV       = 65536,
  parameter int NUM_DIGITS     = 2,
  parameter int MODULUS        = 6,
  parameter int LED_HOLD_TICKS = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  tick_bcd_counter_disp_if.slave  bus
);

  localparam int CW     = BCD_W * NUM_DIGITS;
  localparam int PRE_W  = $clog2(TICK_DIV);
  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int HOLD_W = $clog2(LED_HOLD_TICKS + 1);
  localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(TICK_DIV - 1);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(LED_HOLD_TICKS);
  localparam logic [15:0]       MAX_FULL  = int_to_bcd(MODULUS - 1);
  localparam logic [CW-1:0]     MAX_BCD   = MAX_FULL[CW-1:0];

  logic [PRE_W-1:0]      pre_q, pre_d;
  logic                  tick_q, tick_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  led_q, led_d;
  logic [HOLD_W-1:0]     hold_q, hold_d;
  logic [SCAN_W-1:0]     scan_q, scan_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [7:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;

  logic [CW-1:0]    count_inc, count_dec;
  logic             wrap;
  logic [BCD_W-1:0] digit_sel;

  // Ripple BCD carry/borrow across digits
  always_comb begin
    logic carry, borrow;
    count_inc = count_q;
    count_dec = count_q;
    carry     = 1'b1;
    borrow    = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (carry) begin
        if (count_q[i*BCD_W +: BCD_W] == 4'd9) begin
          count_inc[i*BCD_W +: BCD_W] = 4'd0;
        end else begin
          count_inc[i*BCD_W +: BCD_W] = count_q[i*BCD_W +: BCD_W] + 4'd1;
          carry = 1'b0;
        end
      end
      if (borrow) begin
        if (count_q[i*BCD_W +: BCD_W] == 4'd0) begin
          count_dec[i*BCD_W +: BCD_W] = 4'd9;
        end else begin
          count_dec[i*BCD_W +: BCD_W] = count_q[i*BCD_W +: BCD_W] - 4'd1;
          borrow = 1'b0;
        end
      end
    end
  end

  assign wrap = bus.dir ? (count_q == MAX_BCD) : (count_q == '0);

  always_comb begin
    pre_d   = (pre_q == PRE_LAST) ? '0 : pre_q + 1'b1;
    tick_d  = (pre_q == PRE_LAST);
    count_d = count_q;
    led_d   = led_q;
    hold_d  = hold_q;
    if (bus.clear) begin
      pre_d   = '0;
      tick_d  = 1'b0;
      count_d = '0;
      led_d   = 1'b0;
      hold_d  = '0;
    end else if (tick_q && bus.en) begin
      if (wrap) begin
        count_d = bus.dir ? '0 : MAX_BCD;
        led_d   = 1'b1;
        hold_d  = HOLD_LOAD;
      end else begin
        count_d = bus.dir ? count_inc : count_dec;
        if (hold_q != '0) begin
          hold_d = hold_q - 1'b1;
          if (hold_q == HOLD_W'(1)) led_d = 1'b0;
        end
      end
    end
  end

  // Scan runs freely; clear does not disturb the display rotation
  always_comb begin
    scan_d = (scan_q == SCAN_LAST) ? '0 : scan_q + 1'b1;
    idx_d  = idx_q;
    if (scan_q == SCAN_LAST) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    an_d   = ~(NUM_DIGITS'(1) << idx_q);
  end

  assign digit_sel = count_q[int'(idx_q)*BCD_W +: BCD_W];

  seg7_decode u_seg7_decode (
    .bcd_i (digit_sel),
    .seg_o (seg_d)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_q   <= '0;
      tick_q  <= 1'b0;
      count_q <= '0;
      led_q   <= 1'b0;
      hold_q  <= '0;
      scan_q  <= '0;
      idx_q   <= '0;
      seg_q   <= SEG_BLANK;
      an_q    <= '1;
    end else begin
      pre_q   <= pre_d;
      tick_q  <= tick_d;
      count_q <= count_d;
      led_q   <= led_d;
      hold_q  <= hold_d;
      scan_q  <= scan_d;
      idx_q   <= idx_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
    end
  end

  assign bus.count = count_q;
  assign bus.tick  = tick_q;
  assign bus.led   = led_q;
  assign bus.seg   = seg_q;
  assign bus.an    = an_q;

endmodule
`default_nettype wire

// File: tb/tb_tick_bcd_counter_disp.sv
// tb_tick_bcd_counter_disp: directed checks of tick timing, BCD counting, wrap LED, clear, scan and async reset.
// Rev 1.0
`default_nettype none
module tb_tick_bcd_counter_disp;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  tick_bcd_counter_disp_if #(.NUM_DIGITS(2)) bus_if ();

  tick_bcd_counter_disp #(
    .TICK_DIV       (4),
    .SCAN_DIV       (2),
    .NUM_DIGITS     (2),
    .MODULUS        (12),
    .LED_HOLD_TICKS (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance n rising edges, returning at the following falling edge
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    bus_if.en    = 1'b1;
    bus_if.dir   = 1'b1;
    bus_if.clear = 1'b0;
    cyc(2);
    chk("rst_count", 16'(bus_if.count), 16'h00);
    chk("rst_tick",  16'(bus_if.tick),  16'h0);
    chk("rst_led",   16'(bus_if.led),   16'h0);
    chk("rst_seg",   16'(bus_if.seg),   16'hFF);
    chk("rst_an",    16'(bus_if.an),    16'h3);

    // Edge numbers below count rising edges since reset release
    reset = 1'b0;
    cyc(3);   chk("tick_e3",  16'(bus_if.tick),  16'h0);
    cyc(1);   chk("tick_e4",  16'(bus_if.tick),  16'h1);
              chk("cnt_e4",   16'(bus_if.count), 16'h00);
    cyc(1);   chk("tick_e5",  16'(bus_if.tick),  16'h0);
              chk("cnt_e5",   16'(bus_if.count), 16'h01);
    cyc(32);  chk("cnt_09",   16'(bus_if.count), 16'h09);
    cyc(4);   chk("cnt_10",   16'(bus_if.count), 16'h10);
    cyc(4);   chk("cnt_11",   16'(bus_if.count), 16'h11);
              chk("led_pre",  16'(bus_if.led),   16'h0);
    cyc(4);   chk("wrap_cnt", 16'(bus_if.count), 16'h00);
              chk("wrap_led", 16'(bus_if.led),   16'h1);
    cyc(4);   chk("led_h1",   16'(bus_if.led),   16'h1);
    cyc(3);   chk("led_h2",   16'(bus_if.led),   16'h1);
    cyc(1);   chk("led_off",  16'(bus_if.led),   16'h0);
              chk("cnt_02",   16'(bus_if.count), 16'h02);

    bus_if.dir = 1'b0;
    cyc(8);   chk("dn_00",    16'(bus_if.count), 16'h00);
    cyc(4);   chk("dn_wrap",  16'(bus_if.count), 16'h11);
              chk("dn_led",   16'(bus_if.led),   16'h1);
    cyc(4);   chk("dn_10",    16'(bus_if.count), 16'h10);
    cyc(4);   chk("dn_09",    16'(bus_if.count), 16'h09);
              chk("dn_ledoff",16'(bus_if.led),   16'h0);

    bus_if.en = 1'b0;
    cyc(3);   chk("en0_tick", 16'(bus_if.tick),  16'h1);
    cyc(9);   chk("en0_hold", 16'(bus_if.count), 16'h09);
    bus_if.en = 1'b1;
    cyc(16);  chk("cnt_05",   16'(bus_if.count), 16'h05);
    cyc(3);   chk("clr_tick", 16'(bus_if.tick),  16'h1);
    bus_if.clear = 1'b1;
    cyc(1);
    bus_if.clear = 1'b0;
              chk("clr_cnt",  16'(bus_if.count), 16'h00);
              chk("clr_tk0",  16'(bus_if.tick),  16'h0);
              chk("clr_led",  16'(bus_if.led),   16'h0);
    cyc(3);   chk("clr_pre3", 16'(bus_if.tick),  16'h0);
    cyc(1);   chk("clr_pre4", 16'(bus_if.tick),  16'h1);
    cyc(1);   chk("clr_wrap", 16'(bus_if.count), 16'h11);
              chk("clr_wled", 16'(bus_if.led),   16'h1);

    // Edges 115..118 since release: count reaches 10 at edge 118; scan phase
    // index after edge k is (k/2)%2, displayed one edge later.
    cyc(4);   chk("scan_cnt", 16'(bus_if.count), 16'h10);
    cyc(1);   chk("scan_an1", 16'(bus_if.an),    16'h1);
              chk("scan_sg1", 16'(bus_if.seg),   16'h9F);
    cyc(1);   chk("scan_an1b",16'(bus_if.an),    16'h1);
    cyc(1);   chk("scan_an0", 16'(bus_if.an),    16'h2);
              chk("scan_sg0", 16'(bus_if.seg),   16'h03);
              chk("pre_led",  16'(bus_if.led),   16'h1);
              chk("pre_tick", 16'(bus_if.tick),  16'h1);

    #2 reset = 1'b1;
    #1;
    chk("ar_count", 16'(bus_if.count), 16'h00);
    chk("ar_tick",  16'(bus_if.tick),  16'h0);
    chk("ar_led",   16'(bus_if.led),   16'h0);
    chk("ar_seg",   16'(bus_if.seg),   16'hFF);
    chk("ar_an",    16'(bus_if.an),    16'h3);
    cyc(1);
    reset = 1'b0;
    bus_if.dir = 1'b1;
    cyc(4);   chk("rs_tick",  16'(bus_if.tick),  16'h1);
              chk("rs_cnt0",  16'(bus_if.count), 16'h00);
    cyc(1);   chk("rs_cnt1",  16'(bus_if.count), 16'h01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
